// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM generator / capture pair.
// Holds the measurement FSM encoding and the default counter width.
package pwm_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

endpackage

// File: rtl/sync_edge.sv
// Synchroniser for one asynchronous input, followed by single-cycle rise/fall
// detection on the synchronised level. Usable for any slow async input pin.
module sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  =  sync_q[SYNC_STAGES-1] & ~prev_q;
    assign fall  = ~sync_q[SYNC_STAGES-1] &  prev_q;

endmodule

// File: rtl/pwm_capture.sv
// Measures an incoming PWM waveform: period (rise to rise) and high time
// (rise to fall) in clk ticks, with a valid strobe and a stuck-line flag.
module pwm_capture
    import pwm_pkg::*;
#(
    parameter int          WIDTH       = DEFAULT_WIDTH,
    parameter int          SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = (1 << WIDTH) - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic [WIDTH-1:0] period,
    output logic [WIDTH-1:0] duty,
    output logic             valid,
    output logic             stuck,
    output logic             level
);

    localparam logic [WIDTH-1:0] CTR_MAX   = '1;
    localparam logic [WIDTH-1:0] TIMEOUT_V = WIDTH'(TIMEOUT);

    logic rise, fall, level_s;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst  (rst),
        .in   (in),
        .level(level_s),
        .rise (rise),
        .fall (fall)
    );

    state_e           state_q, state_d;
    logic [WIDTH-1:0] ctr_q, ctr_d;
    logic [WIDTH-1:0] hi_lat_q, hi_lat_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             timed_out;

    // Timeout only counts when no edge arrived this cycle; an edge always wins.
    assign timed_out = (ctr_q == TIMEOUT_V) && !rise && !fall;

    // Free-running tick counter, restarted by every rise and saturating at max.
    always_comb begin
        if (rise) begin
            ctr_d = WIDTH'(1);
        end else if (ctr_q == CTR_MAX) begin
            ctr_d = ctr_q;
        end else begin
            ctr_d = ctr_q + WIDTH'(1);
        end
    end

    // NOTE: every variable gets its hold value first, so no path through the
    // case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        hi_lat_d = hi_lat_q;
        period_d = period_q;
        duty_d   = duty_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_HIGH;
                    stuck_d = 1'b0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d  = ST_LOW;
                    hi_lat_d = ctr_q;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    stuck_d = 1'b1;
                end
            end
            ST_LOW: begin
                if (rise) begin
                    state_d  = ST_HIGH;
                    period_d = ctr_q;
                    duty_d   = hi_lat_q;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b0;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                    stuck_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: the high-time latch is reset along with everything else so a
    // measurement after reset can never report a stale value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ctr_q    <= '0;
            hi_lat_q <= '0;
            period_q <= '0;
            duty_q   <= '0;
            valid_q  <= 1'b0;
            stuck_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctr_q    <= ctr_d;
            hi_lat_q <= hi_lat_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            valid_q  <= valid_d;
            stuck_q  <= stuck_d;
        end
    end

    assign period = period_q;
    assign duty   = duty_q;
    assign valid  = valid_q;
    assign stuck  = stuck_q;
    assign level  = level_s;

endmodule
